// File: rtl/blockram_system_v2_ocrom_loader.sv
// rtl/blockram_system_v2_ocrom_loader.sv - byte-stream boot loader with readback verify for instruction memory
//
// Purpose: packs a little-endian byte stream into 32-bit words, writes them to the
// instruction memory through its debug write path, reads the image back, compares
// sums and releases the CPU reset only after a verified load.
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   start, num_words                load request and its word count (1..NUM_WORDS)
//   rx_data, rx_valid, rx_ready     byte stream handshake
//   mem_*                           target memory port (address registered, q unregistered)
//   cpu_reset_req                   high holds the CPU in reset
//   busy, done, error, checksum     status; checksum valid while done

module blockram_system_v2_ocrom_loader #(
    parameter int ADDR_WIDTH        = 10,
    parameter int NUM_WORDS         = 1024,
    parameter bit HOLD_CPU_AT_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_debugaccess,
    output logic [31:0]           mem_writedata,
    output logic                  mem_clken,
    input  logic [31:0]           mem_readdata,
    output logic                  cpu_reset_req,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH + 1)'(NUM_WORDS);
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH + 1)'(1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] index;
    logic [ADDR_WIDTH:0]   count;
    logic [1:0]            lane;
    logic [31:0]           word;
    logic [31:0]           wsum;
    logic [31:0]           rsum;

    logic                  nw_legal;
    logic                  last_word;
    logic [31:0]           rsum_next;

    assign nw_legal  = (num_words != '0) && (num_words <= MAX_WORDS);
    // count is at least 1 whenever this is used, so count-1 never underflows
    assign last_word = ({1'b0, index} == (count - ONE_WORD));
    assign rsum_next = rsum + mem_readdata;

    assign mem_address     = index;
    assign mem_byteenable  = 4'hF;
    assign mem_clken       = 1'b1;
    assign mem_writedata   = word;
    assign mem_debugaccess = mem_write;

    assign busy  = (state == S_RECV) || (state == S_WRITE) ||
                   (state == S_RD_ADDR) || (state == S_RD_DATA);
    assign done  = (state == S_DONE);
    assign error = (state == S_ERROR);

    always_comb begin
        state_next     = state;
        rx_ready       = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_next = nw_legal ? S_RECV : S_ERROR;
                end
            end
            S_RECV: begin
                rx_ready = 1'b1;
                if (rx_valid && (lane == 2'd3)) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                state_next     = last_word ? S_RD_ADDR : S_RECV;
            end
            S_RD_ADDR: begin
                mem_chipselect = 1'b1;
                state_next     = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (last_word) begin
                    state_next = (wsum == rsum_next) ? S_DONE : S_ERROR;
                end else begin
                    state_next = S_RD_ADDR;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // strobes are masked while reset is high so an interrupted WRITE
        // cannot land in memory on the reset edge
        if (reset) begin
            rx_ready       = 1'b0;
            mem_chipselect = 1'b0;
            mem_write      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            index         <= '0;
            count         <= '0;
            lane          <= 2'd0;
            word          <= 32'd0;
            wsum          <= 32'd0;
            rsum          <= 32'd0;
            checksum      <= 32'd0;
            cpu_reset_req <= HOLD_CPU_AT_RESET;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        index         <= '0;
                        count         <= num_words;
                        lane          <= 2'd0;
                        wsum          <= 32'd0;
                        rsum          <= 32'd0;
                        checksum      <= 32'd0;
                        cpu_reset_req <= 1'b1;
                    end
                end
                S_RECV: begin
                    if (rx_valid) begin
                        word[{lane, 3'b000} +: 8] <= rx_data;
                        lane                      <= lane + 2'd1;
                    end
                end
                S_WRITE: begin
                    wsum  <= wsum + word;
                    index <= last_word ? '0 : index + 1'b1;
                end
                S_RD_DATA: begin
                    rsum <= rsum_next;
                    if (last_word) begin
                        if (wsum == rsum_next) begin
                            checksum      <= wsum;
                            cpu_reset_req <= 1'b0;
                        end
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blockram_system_v2_ocrom_loader.sv
// tb/tb_blockram_system_v2_ocrom_loader.sv - self-checking bench for the boot loader

module tb_blockram_system_v2_ocrom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] num_words;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic        mem_debugaccess;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;
    logic        cpu_reset_req;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    always #5 clk = ~clk;

    blockram_system_v2_ocrom_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_words      (num_words),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_debugaccess(mem_debugaccess),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .cpu_reset_req  (cpu_reset_req),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .checksum       (checksum)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // memory model: registered address, unregistered q, optional bit flip on word 1
    logic [31:0] tb_mem [0:1023];
    logic [9:0]  addr_q = '0;
    logic        clear_mem = 1'b0;
    logic        corrupt = 1'b0;

    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'hA5A5_A5A5;
        end else if (mem_chipselect && mem_write && mem_debugaccess) begin
            tb_mem[mem_address] <= mem_writedata;
        end
        if (mem_clken && mem_chipselect) addr_q <= mem_address;
    end
    assign mem_readdata = tb_mem[addr_q] ^ ((corrupt && addr_q == 10'd1) ? 32'd1 : 32'd0);

    // reference image
    logic [7:0]  stream    [0:4095];
    logic [31:0] exp_words [0:1023];
    int wr_count = 0;
    int rd_count = 0;
    int cs_count = 0;
    logic prev_rd = 1'b0;

    always @(negedge clk) begin
        if (mem_chipselect) begin
            cs_count++;
            chk("rx_ready_in_mem_cycle", {31'd0, rx_ready}, 32'd0);
            if (mem_write) begin
                chk("wr_addr", {22'd0, mem_address}, wr_count);
                chk("wr_data", mem_writedata, exp_words[wr_count[9:0]]);
                chk("wr_be", {28'd0, mem_byteenable}, 32'hF);
                chk("wr_dbg", {31'd0, mem_debugaccess}, 32'd1);
                wr_count++;
            end else begin
                chk("rd_addr", {22'd0, mem_address}, rd_count);
                rd_count++;
            end
        end
        if (prev_rd) chk("rx_ready_in_rd_data", {31'd0, rx_ready}, 32'd0);
        prev_rd = mem_chipselect && !mem_write;
    end

    typedef struct {
        int          nw;
        int          kind;      // 0: fixed 8-byte vector, 1: incrementing words, 2: random bytes
        int          gap_pct;
        bit          bad_rd;
        int          poke;      // byte index at which a start is pulsed while busy, -1 none
        bit          use_const;
        logic [31:0] const_sum;
    } vec_t;

    task automatic build_stream(input int nw, input int kind);
        logic [7:0] fixed [0:7];
        fixed = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (kind == 0) stream[4*w+b] = fixed[(4*w+b) % 8];
                else if (kind == 1) stream[4*w+b] = 8'((w >> (8*b)) & 255);
                else stream[4*w+b] = 8'($urandom_range(255));
            end
        end
    endtask

    task automatic run_load(input vec_t v);
        logic [31:0] sum;
        int idx;
        int cyc;
        bit ok;
        sum = 0;
        for (int w = 0; w < v.nw; w++) begin
            exp_words[w] = 32'(stream[4*w]) + 32'(stream[4*w+1]) * 256 +
                           32'(stream[4*w+2]) * 65536 + 32'(stream[4*w+3]) * 16777216;
            sum = sum + exp_words[w];
        end
        if (v.use_const) sum = v.const_sum;
        ok = !v.bad_rd;
        corrupt = v.bad_rd;
        @(negedge clk); clear_mem = 1'b1;
        @(negedge clk); clear_mem = 1'b0;
        wr_count = 0; rd_count = 0;
        start = 1'b1; num_words = 11'(v.nw);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_cleared", {31'd0, done}, 32'd0);
        chk("cpu_held_loading", {31'd0, cpu_reset_req}, 32'd1);
        idx = 0; cyc = 0;
        while (idx < 4 * v.nw && cyc < 20000) begin
            start     = (idx == v.poke);
            num_words = (idx == v.poke) ? 11'd0 : 11'(v.nw);
            rx_valid  = ($urandom_range(99) >= v.gap_pct);
            rx_data   = rx_valid ? stream[idx] : 8'($urandom_range(255));
            if (rx_valid && rx_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; rx_valid = 1'b0;
        chk("all_bytes_accepted", idx, 4 * v.nw);
        cyc = 0;
        while (!(done || error) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk("finished_in_time", {31'd0, done || error}, 32'd1);
        chk("done", {31'd0, done}, {31'd0, ok});
        chk("error", {31'd0, error}, {31'd0, !ok});
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("cpu_reset_req_end", {31'd0, cpu_reset_req}, {31'd0, !ok});
        if (ok) chk("checksum", checksum, sum);
        chk("write_count", wr_count, v.nw);
        chk("read_count", rd_count, v.nw);
        for (int w = 0; w < v.nw; w++) chk("mem_image", tb_mem[w], exp_words[w]);
        corrupt = 1'b0;
    endtask

    vec_t vecs [8];
    int   cs_before;

    initial begin
        vecs[0] = '{2,    0, 0,  1'b0, -1, 1'b1, 32'hF0E2_1567};
        vecs[1] = '{2,    0, 40, 1'b0, -1, 1'b1, 32'hF0E2_1567};
        vecs[2] = '{1024, 1, 0,  1'b0, -1, 1'b1, 32'h0007_FE00};
        vecs[3] = '{2,    0, 0,  1'b1, -1, 1'b0, 32'd0};
        vecs[4] = '{5,    2, 30, 1'b0, -1, 1'b0, 32'd0};
        vecs[5] = '{1,    2, 0,  1'b0, -1, 1'b0, 32'd0};
        vecs[6] = '{17,   2, 50, 1'b0, 6,  1'b0, 32'd0};
        vecs[7] = '{3,    2, 20, 1'b1, -1, 1'b0, 32'd0};

        reset = 1'b1; start = 1'b0; num_words = '0; rx_data = '0; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_cs", {31'd0, mem_chipselect}, 32'd0);
        chk("rst_addr", {22'd0, mem_address}, 32'd0);
        chk("rst_wdata", mem_writedata, 32'd0);
        chk("rst_status", {29'd0, busy, done, error}, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        chk("rst_cpu", {31'd0, cpu_reset_req}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            build_stream(vecs[i].nw, vecs[i].kind);
            run_load(vecs[i]);
        end

        // illegal word counts
        cs_before = cs_count;
        start = 1'b1; num_words = 11'd0;
        @(negedge clk);
        start = 1'b0;
        chk("err_nw0", {31'd0, error}, 32'd1);
        chk("err_nw0_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b1; num_words = 11'd1025;
        @(negedge clk);
        start = 1'b0;
        chk("err_nw1025", {31'd0, error}, 32'd1);
        chk("err_nw1025_done", {31'd0, done}, 32'd0);
        chk("err_cpu", {31'd0, cpu_reset_req}, 32'd1);
        repeat (4) @(negedge clk);
        chk("err_no_mem_access", cs_count, cs_before);

        // reset in the middle of word 0
        start = 1'b1; num_words = 11'd1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rx_valid = 1'b1; rx_data = 8'hAA + 8'(b);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        cs_before = cs_count;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("mid_rst_status", {29'd0, busy, done, error}, 32'd0);
        chk("mid_rst_wdata", mem_writedata, 32'd0);
        chk("mid_rst_cpu", {31'd0, cpu_reset_req}, 32'd1);
        chk("mid_rst_no_strobe", cs_count, cs_before);
        reset = 1'b0;
        @(negedge clk);
        stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
        run_load('{1, 3, 0, 1'b0, -1, 1'b1, 32'h4433_2211});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
